// File: rtl/m_pipe_pkg.sv
// Shared helpers for the m_pipe_arst elastic register pipeline:
// occupancy-width math and the output hold-stability assertion macro.
`ifndef M_PIPE_PKG_SV
`define M_PIPE_PKG_SV

// A valid word that is not taken must keep valid and data steady until taken or cleared.
`define M_PIPE_ASSERT_HOLD(name, ck, rn, vld, rdy, clr, dat) \
   name: assert property (@(posedge ck) disable iff (!(rn)) \
      ((vld) && !(rdy) && !(clr)) |=> ((vld) && $stable(dat)));

package m_pipe_pkg;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

   // Counter must represent 0..depth inclusive.
   function automatic int unsigned occ_width(input int unsigned depth);
      return clog2(depth + 1);
   endfunction

endpackage

`endif

// File: rtl/m_pipe_stage.sv
// One elastic register slice: data plus valid bit, async active-low reset,
// loads from upstream whenever it is empty or its content moves on.
module m_pipe_stage
   import m_pipe_pkg::*;
#(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             CK,
   input  logic             RN,
   input  logic             FLUSH,
   input  logic             up_vld,
   input  logic [WIDTH-1:0] up_data,
   input  logic             dn_rdy,
   output logic             vld,
   output logic [WIDTH-1:0] data,
   output logic             rdy
);

   assign rdy = !vld || dn_rdy;

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         vld <= 1'b0;
      end else if (FLUSH) begin
         vld <= 1'b0;
      end else if (rdy) begin
         vld <= up_vld;
      end
   end

   // Data only toggles when a real word arrives; bubbles leave it untouched.
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         data <= RST_VAL;
      end else if (FLUSH) begin
         data <= RST_VAL;
      end else if (rdy && up_vld) begin
         data <= up_data;
      end
   end

endmodule

// File: rtl/m_pipe_arst.sv
// WIDTH-bit, DEPTH-stage elastic register pipeline with collapsing bubbles.
// Optional occupancy counter on OCC enabled by defining M_PIPE_OCC_CNT_EN.
module m_pipe_arst
   import m_pipe_pkg::*;
#(
   parameter int unsigned      WIDTH   = 8,
   parameter int unsigned      DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                          CK,
   input  logic                          RN,
   input  logic                          FLUSH,
   input  logic                          IN_VLD,
   output logic                          IN_RDY,
   input  logic [WIDTH-1:0]              D,
   output logic                          OUT_VLD,
   input  logic                          OUT_RDY,
   output logic [WIDTH-1:0]              Q,
   output logic [occ_width(DEPTH)-1:0]   OCC
);

   localparam int unsigned OCC_W = occ_width(DEPTH);

   logic [DEPTH-1:0] stage_vld;
   logic [WIDTH-1:0] stage_data [DEPTH];

   // Stage 0 faces the input, stage DEPTH-1 drives Q; ready ripples backwards.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             up_vld;
      logic [WIDTH-1:0] up_data;
      logic             dn_rdy;
      logic             rdy;

      if (i == 0) begin : g_head
         assign up_vld  = IN_VLD;
         assign up_data = D;
      end else begin : g_body
         assign up_vld  = stage_vld[i-1];
         assign up_data = stage_data[i-1];
      end

      if (i == DEPTH - 1) begin : g_tail
         assign dn_rdy = OUT_RDY;
      end else begin : g_mid
         assign dn_rdy = g_stage[i+1].rdy;
      end

      m_pipe_stage #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_stage (
         .CK      (CK),
         .RN      (RN),
         .FLUSH   (FLUSH),
         .up_vld  (up_vld),
         .up_data (up_data),
         .dn_rdy  (dn_rdy),
         .vld     (stage_vld[i]),
         .data    (stage_data[i]),
         .rdy     (rdy)
      );
   end

   assign IN_RDY  = g_stage[0].rdy && !FLUSH;
   assign OUT_VLD = stage_vld[DEPTH-1];
   assign Q       = stage_data[DEPTH-1];

`ifdef M_PIPE_OCC_CNT_EN
   logic             in_hs;
   logic             out_hs;
   logic [OCC_W-1:0] occ;

   assign in_hs  = IN_VLD && IN_RDY;
   assign out_hs = OUT_VLD && OUT_RDY;

   // Net change per edge: push-only +1, pop-only -1, both or neither hold.
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         occ <= '0;
      end else if (FLUSH) begin
         occ <= '0;
      end else if (in_hs && !out_hs) begin
         occ <= occ + OCC_W'(1);
      end else if (out_hs && !in_hs) begin
         occ <= occ - OCC_W'(1);
      end
   end

   assign OCC = occ;

   a_occ_match: assert property (@(posedge CK) disable iff (!RN)
      OCC == OCC_W'($countones(stage_vld)));
`else
   assign OCC = '0;
`endif

   `M_PIPE_ASSERT_HOLD(a_out_hold, CK, RN, OUT_VLD, OUT_RDY, FLUSH, Q)

endmodule

// File: tb/tb_m_pipe_arst.sv
// Directed bench for m_pipe_arst (WIDTH=8, DEPTH=3, RST_VAL=8'hA5) with a
// word/position queue model compared on every falling clock edge.
module tb_m_pipe_arst;

   localparam int unsigned WIDTH = 8;
   localparam int          DEP   = 3;
   localparam logic [7:0]  RSTV  = 8'hA5;
   localparam int unsigned OCC_W = $clog2(DEP + 1);
`ifdef M_PIPE_OCC_CNT_EN
   localparam int OCC_ON = 1;
`else
   localparam int OCC_ON = 0;
`endif

   logic             CK;
   logic             RN;
   logic             FLUSH;
   logic             IN_VLD;
   logic             IN_RDY;
   logic [WIDTH-1:0] D;
   logic             OUT_VLD;
   logic             OUT_RDY;
   logic [WIDTH-1:0] Q;
   logic [OCC_W-1:0] OCC;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mq[$];
   int         mp[$];
   logic [7:0] got[$];

   m_pipe_arst #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEP),
      .RST_VAL (RSTV)
   ) dut (
      .CK      (CK),
      .RN      (RN),
      .FLUSH   (FLUSH),
      .IN_VLD  (IN_VLD),
      .IN_RDY  (IN_RDY),
      .D       (D),
      .OUT_VLD (OUT_VLD),
      .OUT_RDY (OUT_RDY),
      .Q       (Q),
      .OCC     (OCC)
   );

   initial begin
      CK = 1'b0;
      forever #5 CK = ~CK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Queue model: each word carries its stage position and moves on when any slot ahead is free or the head leaves.
   always @(negedge CK or negedge RN) begin : p_model
      logic m_in_rdy;
      logic m_out_vld;
      logic pop;
      int   occ_exp;
      if (!RN) begin
         mq.delete();
         mp.delete();
      end else begin
         m_in_rdy  = !FLUSH && ((mq.size() < DEP) || OUT_RDY);
         m_out_vld = (mq.size() > 0) && (mp[0] == DEP - 1);
         occ_exp   = (OCC_ON != 0) ? mq.size() : 0;
         check("model_in_rdy", 32'(IN_RDY), 32'(m_in_rdy));
         check("model_out_vld", 32'(OUT_VLD), 32'(m_out_vld));
         if (m_out_vld) check("model_q", 32'(Q), 32'(mq[0]));
         check("model_occ", 32'(OCC), 32'(occ_exp));
         if (FLUSH) begin
            mq.delete();
            mp.delete();
         end else begin
            pop = m_out_vld && OUT_RDY;
            for (int k = 0; k < mp.size(); k++) begin
               if (pop || (k < DEP - 1 - mp[k])) mp[k]++;
            end
            if (pop) begin
               void'(mq.pop_front());
               void'(mp.pop_front());
            end
            if (IN_VLD && m_in_rdy) begin
               mq.push_back(D);
               mp.push_back(0);
            end
         end
      end
   end

   always @(negedge CK) begin
      if (RN && OUT_VLD && OUT_RDY) got.push_back(Q);
   end

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   task automatic drain();
      IN_VLD  = 1'b0;
      OUT_RDY = 1'b1;
      repeat (DEP + 2) step();
   endtask

   task automatic check_log(input string nm, input int n, input logic [7:0] base, input logic [7:0] stepv);
      check({nm, "_count"}, 32'(got.size()), 32'(n));
      for (int k = 0; k < n && k < got.size(); k++)
         check(nm, 32'(got[k]), 32'(8'(base + stepv * 8'(k + 1))));
      got.delete();
   endtask

   initial begin
      RN      = 1'b1;
      FLUSH   = 1'b0;
      IN_VLD  = 1'b0;
      OUT_RDY = 1'b0;
      D       = '0;

      // Reset with no clock edge
      #2 RN = 1'b0;
      #1;
      check("rst_out_vld", 32'(OUT_VLD), 32'd0);
      check("rst_q", 32'(Q), 32'(RSTV));
      check("rst_occ", 32'(OCC), 32'd0);
      step();
      step();
      RN = 1'b1;
      #1;
      check("rst_in_rdy", 32'(IN_RDY), 32'd1);

      // Streaming at full rate
      OUT_RDY = 1'b1;
      got.delete();
      for (int k = 1; k <= 16; k++) begin
         D      = 8'(k);
         IN_VLD = 1'b1;
         #1;
         check("stream_in_rdy", 32'(IN_RDY), 32'd1);
         step();
         if (k == 2) check("lat_early", 32'(OUT_VLD), 32'd0);
         if (k == 3) begin
            check("lat_vld", 32'(OUT_VLD), 32'd1);
            check("lat_q", 32'(Q), 32'h01);
         end
      end
      drain();
      check_log("stream_order", 16, 8'h00, 8'h01);

      // Backpressure fill
      OUT_RDY = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         D      = 8'(8'h11 * 8'(k));
         IN_VLD = 1'b1;
         #1;
         check("fill_in_rdy", 32'(IN_RDY), 32'd1);
         step();
      end
      D = 8'h44;
      #1;
      check("fill_full_in_rdy", 32'(IN_RDY), 32'd0);
      check("fill_occ", 32'(OCC), 32'(3 * OCC_ON));
      step();
      step();
      check("fill_stall_in_rdy", 32'(IN_RDY), 32'd0);
      check("fill_head_q", 32'(Q), 32'h11);
      OUT_RDY = 1'b1;
      #1;
      check("fill_popfree_in_rdy", 32'(IN_RDY), 32'd1);
      step();
      drain();
      check_log("bp_order", 4, 8'h00, 8'h11);

      // Bubble collapse while stalled
      OUT_RDY = 1'b0;
      D       = 8'hB1;
      IN_VLD  = 1'b1;
      step();
      IN_VLD = 1'b0;
      step();
      step();
      check("bubble_out_vld", 32'(OUT_VLD), 32'd1);
      check("bubble_q", 32'(Q), 32'hB1);
      for (int k = 2; k <= 3; k++) begin
         D      = 8'(8'hB0 + 8'(k));
         IN_VLD = 1'b1;
         #1;
         check("bubble_in_rdy", 32'(IN_RDY), 32'd1);
         step();
      end
      D = 8'hB4;
      #1;
      check("bubble_full", 32'(IN_RDY), 32'd0);

      // Simultaneous push and pop on a full pipe
      OUT_RDY = 1'b1;
      #1;
      check("swap_in_rdy", 32'(IN_RDY), 32'd1);
      step();
      IN_VLD  = 1'b0;
      OUT_RDY = 1'b0;
      #1;
      check("swap_occ", 32'(OCC), 32'(3 * OCC_ON));
      check("swap_q", 32'(Q), 32'hB2);
      drain();
      check_log("swap_order", 4, 8'hB0, 8'h01);

      // Flush with two words held
      OUT_RDY = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         D      = 8'(8'h60 + 8'(k));
         IN_VLD = 1'b1;
         step();
      end
      IN_VLD = 1'b0;
      step();
      FLUSH  = 1'b1;
      IN_VLD = 1'b1;
      D      = 8'h55;
      #1;
      check("flush_in_rdy", 32'(IN_RDY), 32'd0);
      step();
      FLUSH  = 1'b0;
      IN_VLD = 1'b0;
      #1;
      check("flush_out_vld", 32'(OUT_VLD), 32'd0);
      check("flush_occ", 32'(OCC), 32'd0);
      check("flush_q", 32'(Q), 32'(RSTV));
      drain();
      check("flush_no_out", 32'(got.size()), 32'd0);
      got.delete();

      // Reset asserted mid-stream
      OUT_RDY = 1'b0;
      D       = 8'h71;
      IN_VLD  = 1'b1;
      step();
      step();
      step();
      #2 RN = 1'b0;
      #1;
      check("arst_out_vld", 32'(OUT_VLD), 32'd0);
      check("arst_q", 32'(Q), 32'(RSTV));
      check("arst_occ", 32'(OCC), 32'd0);
      IN_VLD = 1'b0;
      step();
      RN = 1'b1;
      #1;
      check("arst_in_rdy", 32'(IN_RDY), 32'd1);
      drain();
      check("arst_no_out", 32'(got.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
